// File: rtl/coherent_dcache_ctrl.sv
// MSI snooping data-cache controller: direct-mapped, 2-word blocks, one per CPU.
// Define FLUSH_EN to add halt/flushed and the write-back-all sequence.
module coherent_dcache_ctrl #(
  parameter int NSETS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
`ifdef FLUSH_EN
  input  logic        halt,
  output logic        flushed,
`endif
  output logic        have
);

  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = 29 - IDXW;

  typedef enum logic [2:0] {
    IDLE, WB0, WB1, FILL0, FILL1, FLUSH, FDONE
  } state_t;

  logic [NSETS-1:0] valid;
  logic [NSETS-1:0] dirty;
  logic [TAGW-1:0]  tags [NSETS];
  logic [31:0]      w0 [NSETS];
  logic [31:0]      w1 [NSETS];

  state_t          state;
  logic [IDXW-1:0] ridx;
  logic [TAGW-1:0] rtag;
  logic            scnt;

  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] sidx;
  logic [TAGW-1:0] tg;
  logic [TAGW-1:0] stg;
  logic            req;
  logic            tmatch;
  logic            smatch;
  logic            ack;
  logic            unused_bits;

  assign idx  = dmemaddr[IDXW+2:3];
  assign tg   = dmemaddr[31:IDXW+3];
  assign sidx = ccsnoopaddr[IDXW+2:3];
  assign stg  = ccsnoopaddr[31:IDXW+3];
  assign unused_bits = ^{dmemaddr[1:0], ccsnoopaddr[1:0]};

  assign req    = dmemREN | dmemWEN;
  assign tmatch = valid[idx] && (tags[idx] == tg);
  assign smatch = ccwait && valid[sidx] && (tags[sidx] == stg);
  assign have   = smatch && dirty[sidx];
  // a dwait drop during a snoop belongs to the snooper, not to us
  assign ack    = !dwait && !ccwait;

  assign dhit = (state == IDLE) && req && tmatch && !ccwait
             && (dmemREN || dirty[idx]);
  assign dmemload = (dhit && dmemREN)
                  ? (dmemaddr[2] ? w1[idx] : w0[idx]) : '0;

  assign dWEN    = (state == WB0) || (state == WB1);
  assign dREN    = (state == FILL0) || (state == FILL1);
  assign cctrans = dREN;
  assign ccwrite = dREN && dmemWEN;
  assign daddr   = dWEN ? {tags[ridx], ridx, 3'b000}
                 : dREN ? {rtag, ridx, 3'b000} : '0;

  always_comb begin
    dstore = '0;
    if (ccwait)
      dstore = ccsnoopaddr[2] ? w1[sidx] : w0[sidx];
    else if (state == WB0)
      dstore = w0[ridx];
    else if (state == WB1)
      dstore = w1[ridx];
  end

`ifdef FLUSH_EN
  logic [IDXW-1:0] fidx;
  logic            fl;
  logic            flast;
  assign flast   = fidx == IDXW'(NSETS - 1);
  assign flushed = state == FDONE;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      ridx  <= '0;
      rtag  <= '0;
      scnt  <= 1'b0;
`ifdef FLUSH_EN
      fidx  <= '0;
      fl    <= 1'b0;
`endif
    end else begin
      if (!ccwait) begin
        scnt <= 1'b0;
      end else if (have && !dwait) begin
        scnt <= !scnt;
        if (scnt) begin
          if (ccinv) valid[sidx] <= 1'b0;
          else       dirty[sidx] <= 1'b0;
        end
      end else if (ccinv && smatch && !dirty[sidx]) begin
        valid[sidx] <= 1'b0;
      end

      // fill results are assigned last so they win over a same-set snoop
      unique case (state)
        IDLE: begin
`ifdef FLUSH_EN
          if (halt) begin
            state <= FLUSH;
            fidx  <= '0;
            fl    <= 1'b1;
          end else
`endif
          if (req && !ccwait && !dhit) begin
            ridx <= idx;
            rtag <= tg;
            if (valid[idx] && dirty[idx]) begin
              state <= WB0;
            end else begin
              valid[idx] <= 1'b0;
              state <= FILL0;
            end
          end
        end
        WB0: if (ack) state <= WB1;
        WB1: if (ack) begin
          valid[ridx] <= 1'b0;
          dirty[ridx] <= 1'b0;
`ifdef FLUSH_EN
          if (fl) begin
            fidx  <= fidx + 1'b1;
            state <= flast ? FDONE : FLUSH;
          end else
`endif
          state <= FILL0;
        end
        FILL0: if (ack) state <= FILL1;
        FILL1: if (ack) begin
          tags[ridx]  <= rtag;
          valid[ridx] <= 1'b1;
          dirty[ridx] <= dmemWEN;
          state <= IDLE;
        end
`ifdef FLUSH_EN
        FLUSH: if (!ccwait) begin
          if (valid[fidx] && dirty[fidx]) begin
            ridx  <= fidx;
            state <= WB0;
          end else begin
            valid[fidx] <= 1'b0;
            fidx <= fidx + 1'b1;
            if (flast) state <= FDONE;
          end
        end
        FDONE: ;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (dhit && dmemWEN) begin
        if (dmemaddr[2]) w1[idx] <= dmemstore;
        else             w0[idx] <= dmemstore;
      end
      if (state == FILL0 && ack) w0[ridx] <= dload;
      if (state == FILL1 && ack) w1[ridx] <= dload;
    end
  end

endmodule
